// File: rtl/ex3_share_ctrl.sv
// ex3_share_ctrl: round-robin arbiter that time-shares one multi-cycle
// test_ex3 unit among N_REQ requesters. One operand is in flight at a time.
// The result, or a timeout error, is returned to the requester that issued it.
module ex3_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int XW      = 4,
  parameter int YW      = 5,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*XW-1:0] req_x,
  output logic [N_REQ-1:0]    gnt,
  output logic                busy,
  output logic [N_REQ-1:0]    rsp_val,
  output logic [YW-1:0]       rsp_y,
  output logic                rsp_err,
  output logic                u_xval,
  output logic [XW-1:0]       u_x,
  input  logic [YW-1:0]       u_y,
  input  logic                u_yval
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [8:0] TO9 = 9'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [XW-1:0]      x_q, x_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_val_q, rsp_val_d;
  logic [YW-1:0]      rsp_y_q, rsp_y_d;
  logic               rsp_err_q, rsp_err_d;
  logic               u_xval_q, u_xval_d;

  logic               sel_found;
  logic [IW-1:0]      sel_idx;

  // Round-robin pick: first requesting index at or after the pointer, wrapping.
  always_comb begin
    int            cand;
    logic [IW-1:0] cand_i;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_i    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand   = (int'(ptr_q) + i) % N_REQ;
      cand_i = IW'(cand);
      if (!sel_found && req[cand_i]) begin
        sel_found = 1'b1;
        sel_idx   = cand_i;
      end
    end
  end

  // Next-state and next-output logic; every output is a flop set on entry
  // to the state in which it must be visible.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    rsp_val_d = '0;
    rsp_y_d   = '0;
    rsp_err_d = 1'b0;
    u_xval_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d          = S_ISSUE;
          idx_d            = sel_idx;
          x_d              = req_x[int'(sel_idx)*XW +: XW];
          gnt_d[sel_idx]   = 1'b1;
          u_xval_d         = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A done pulse on the timeout cycle still counts as a real result.
        if (u_yval) begin
          state_d          = S_RESP;
          rsp_val_d[idx_q] = 1'b1;
          rsp_y_d          = u_y;
        end else if (({1'b0, cnt_q} + 9'd1) == TO9) begin
          state_d          = S_RESP;
          rsp_val_d[idx_q] = 1'b1;
          rsp_err_d        = 1'b1;
        end
      end
      S_RESP: begin
        if (int'(idx_q) == N_REQ - 1) ptr_d = '0;
        else                          ptr_d = idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops everything back to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      rsp_val_q <= '0;
      rsp_y_q   <= '0;
      rsp_err_q <= 1'b0;
      u_xval_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      rsp_val_q <= rsp_val_d;
      rsp_y_q   <= rsp_y_d;
      rsp_err_q <= rsp_err_d;
      u_xval_q  <= u_xval_d;
    end
  end

  assign gnt     = gnt_q;
  assign rsp_val = rsp_val_q;
  assign rsp_y   = rsp_y_q;
  assign rsp_err = rsp_err_q;
  assign u_xval  = u_xval_q;
  assign u_x     = x_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex3_share_ctrl.sv
// Bench for ex3_share_ctrl: a stub unit answers y = 2x+1 after a programmable
// delay; expected responses go into a scoreboard when a request is driven and
// are popped when rsp_val fires.
module tb_ex3_share_ctrl;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*4-1:0] req_x;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [N-1:0]   rsp_val;
  logic [4:0]     rsp_y;
  logic           rsp_err;
  logic           u_xval;
  logic [3:0]     u_x;
  logic [4:0]     u_y;
  logic           u_yval;

  always #5 clk = ~clk;

  ex3_share_ctrl #(.N_REQ(N), .XW(4), .YW(5), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .req(req), .req_x(req_x), .gnt(gnt), .busy(busy),
    .rsp_val(rsp_val), .rsp_y(rsp_y), .rsp_err(rsp_err), .u_xval(u_xval),
    .u_x(u_x), .u_y(u_y), .u_yval(u_yval)
  );

  // Stub unit: done pulse stub_d cycles after the start pulse (0 = never).
  int         stub_d;
  int         tmr;
  logic       pend;
  logic       stub_yval;
  logic [4:0] stub_y;
  logic       spur;

  always @(posedge clk) begin
    if (rst) begin
      stub_yval <= 1'b0;
      pend      <= 1'b0;
      tmr       <= 0;
      stub_y    <= '0;
    end else begin
      stub_yval <= 1'b0;
      if (u_xval) begin
        pend   <= (stub_d >= 2);
        tmr    <= 1;
        stub_y <= {u_x, 1'b1};
      end else if (pend) begin
        if (tmr == stub_d - 1) begin
          stub_yval <= 1'b1;
          pend      <= 1'b0;
        end else begin
          tmr <= tmr + 1;
        end
      end
    end
  end

  assign u_yval = stub_yval | spur;
  assign u_y    = stub_y;

  typedef struct {
    int         idx;
    logic [3:0] x;
    int         dly;
    logic [4:0] y;
    logic       err;
  } vec_t;

  typedef struct {
    int         idx;
    logic [4:0] y;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   glog[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc = 0, rsp_cnt = 0, gnt_cnt = 0, last_rsp = 0;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample #1 after the edge, and feed the scoreboard.
  task automatic step();
    exp_t e;
    int   gi;
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_val != '0) begin
      rsp_cnt++;
      last_rsp = cyc;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp rsp_val=%b (cycle %0d)", rsp_val, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_val", 32'(rsp_val), 32'(1) << e.idx);
        chk("rsp_y",   32'(rsp_y),   32'(e.y));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    if (gnt != '0) begin
      gi = 0;
      for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
      glog.push_back(gi);
      gnt_cnt++;
      chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
      chk("u_xval_with_gnt", 32'(u_xval), 32'd1);
      chk("one_in_flight", 32'(gnt_cnt - rsp_cnt), 32'd1);
    end
  endtask

  task automatic run_one(input vec_t v);
    int n0, g0, t_iss;
    exp_t e;
    stub_d = v.dly;
    e.idx = v.idx; e.y = v.y; e.err = v.err;
    sb.push_back(e);
    req[v.idx] = 1'b1;
    req_x[v.idx*4 +: 4] = v.x;
    n0 = rsp_cnt;
    g0 = gnt_cnt;
    step();
    chk("gnt_latency", 32'(gnt_cnt - g0), 32'd1);
    chk("gnt_bit", 32'(gnt), 32'(1) << v.idx);
    chk("u_x", 32'(u_x), 32'(v.x));
    chk("busy_issue", 32'(busy), 32'd1);
    req[v.idx] = 1'b0;
    t_iss = cyc;
    for (int k = 0; k < 300 && rsp_cnt == n0; k++) step();
    if (rsp_cnt == n0) begin
      checks++;
      fails++;
      $display("FAIL rsp_wait_expired idx=%0d got=none exp=rsp", v.idx);
    end else begin
      chk("rsp_latency", 32'(last_rsp - t_iss), (v.dly == 0) ? 32'd201 : 32'(v.dly + 1));
    end
    step();
    chk("busy_after_resp", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n0;
    vec_t v;
    //            idx  x      dly  y      err
    vecs[0] = '{0, 4'd2,  6,   5'd5,  1'b0};
    vecs[1] = '{1, 4'd7,  3,   5'd15, 1'b0};
    vecs[2] = '{2, 4'd0,  10,  5'd1,  1'b0};
    vecs[3] = '{1, 4'd5,  0,   5'd0,  1'b1};   // unit never answers
    vecs[4] = '{0, 4'd6,  200, 5'd13, 1'b0};   // done lands on timeout cycle
    vecs[5] = '{3, 4'd15, 2,   5'd31, 1'b0};

    rst = 1'b1; req = '0; req_x = '0; spur = 1'b0; stub_d = 0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_gnt",     32'(gnt),     32'd0);
    chk("rst_rsp_val", 32'(rsp_val), 32'd0);
    chk("rst_rsp_y",   32'(rsp_y),   32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_u_xval",  32'(u_xval),  32'd0);
    chk("rst_u_x",     32'(u_x),     32'd0);
    step();

    // Single transactions, including timeout and done-on-timeout.
    foreach (vecs[i]) run_one(vecs[i]);

    // All four at once, each drops its request after its grant.
    req_x = {4'd3, 4'd2, 4'd1, 4'd0};
    stub_d = 6;
    for (int i = 0; i < 4; i++) begin
      e.idx = i; e.y = 5'(2 * i + 1); e.err = 1'b0;
      sb.push_back(e);
    end
    glog.delete();
    n0 = rsp_cnt;
    req = 4'b1111;
    for (int k = 0; k < 200 && rsp_cnt - n0 < 4; k++) begin
      step();
      req = req & ~gnt;
    end
    chk("all4_rsp_count", 32'(rsp_cnt - n0), 32'd4);
    chk("all4_gnt_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("all4_gnt_order", 32'(glog[i]), 32'(i));
    req = '0;
    step();

    // Fairness: requesters 1 and 2 held continuously.
    req_x = {4'd0, 4'd5, 4'd4, 4'd0};
    stub_d = 3;
    for (int i = 0; i < 4; i++) begin
      e.idx = (i % 2 == 0) ? 1 : 2;
      e.y   = (i % 2 == 0) ? 5'd9 : 5'd11;
      e.err = 1'b0;
      sb.push_back(e);
    end
    glog.delete();
    n0 = rsp_cnt;
    req = 4'b0110;
    for (int k = 0; k < 200 && rsp_cnt - n0 < 4; k++) step();
    req = '0;
    chk("fair_gnt_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4 && i < glog.size(); i++)
      chk("fair_gnt_order", 32'(glog[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    repeat (3) step();
    chk("fair_idle", 32'(busy), 32'd0);

    // Spurious done pulse while idle.
    n0 = rsp_cnt;
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("spur_busy", 32'(busy), 32'd0);
    repeat (4) step();
    chk("spur_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    chk("spur_still_idle", 32'(busy), 32'd0);

    // Reset in the middle of WAIT.
    stub_d = 50;
    req[0] = 1'b1;
    req_x[3:0] = 4'd9;
    step();
    req = '0;
    repeat (5) step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy",    32'(busy),    32'd0);
    chk("mid_rst_gnt",     32'(gnt),     32'd0);
    chk("mid_rst_rsp_val", 32'(rsp_val), 32'd0);
    chk("mid_rst_rsp_y",   32'(rsp_y),   32'd0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("mid_rst_u_xval",  32'(u_xval),  32'd0);
    chk("mid_rst_u_x",     32'(u_x),     32'd0);
    rsp_cnt = gnt_cnt;
    n0 = rsp_cnt;
    repeat (60) step();
    chk("mid_rst_no_rsp", 32'(rsp_cnt - n0), 32'd0);
    v = '{0, 4'd3, 6, 5'd7, 1'b0};
    run_one(v);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
